rr_mux_arbiter: RTL and testbench
=================================

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter: MAX_BURST, default 4; maximum consecutive words accepted from one owner before forced rotation (legal range 1..15).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous and active-low.
REQ-004 req  in  8  req[i]=1: requester i has a word presented on mux input i.
REQ-005 mux_out  in  8  output of external Mux8x1 driven by sel.
REQ-006 sel  out  3  registered select to Mux8x1; sel[2]=Select2, sel[1]=Select1, sel[0]=Select0.
REQ-007 gnt  out  8  one-hot pop strobe; gnt[i]=1 for exactly one cycle per word taken from requester i.
REQ-008 out_data  out  8  registered captured word.
REQ-009 out_valid  out  1  out_data holds an undelivered word.
REQ-010 out_ready  in  1  downstream accepts out_data when out_valid && out_ready on a rising edge.
REQ-011 busy  out  1  high whenever state is not ARB.

Function
REQ-012 FSM states SHALL be ARB, CAPT, HOLD; internal regs: owner[2:0], ptr[2:0], burst_cnt[3:0].
REQ-013 ARB: if req==0, remain in ARB, sel unchanged; else choose first i with req[i]=1 scanning ptr, ptr+1, ... mod 8; owner<=i, sel<=i, burst_cnt<=0, go CAPT.
REQ-014 CAPT (one cycle): gnt=onehot(owner) combinationally; at edge out_data<=mux_out, out_valid<=1, burst_cnt<=burst_cnt+1, go HOLD.
REQ-015 gnt SHALL be all-zero in every state except CAPT.
REQ-016 HOLD: out_data and out_valid stable while out_ready=0; no gnt issued.
REQ-017 HOLD with out_ready=1: out_valid<=0; if req[owner]=1 and burst_cnt<MAX_BURST go CAPT (sel unchanged); else ptr<=owner+1 mod 8 (7 wraps to 0) and go ARB.
REQ-018 Latency: req[i] rising in ARB at cycle N -> sel=i and gnt[i]=1 at N+1 -> out_valid=1 at N+2; minimum 2 cycles per word in a burst.
REQ-019 req[owner] dropping during HOLD SHALL not discard the held word; it is delivered, then rotation per REQ-017.
REQ-020 req[owner] dropping during CAPT SHALL not suppress capture or gnt (word taken regardless).
REQ-021 Requesters other than owner SHALL be ignored until return to ARB; no preemption.
REQ-022 Requester i SHALL update its mux input on the edge ending its gnt cycle; arbiter relies on mux_out being valid in every CAPT cycle.

Reset
REQ-023 rst_n=0 at an edge SHALL force: state=ARB, sel=0, owner=0, ptr=0, burst_cnt=0, out_data=0x00, out_valid=0, gnt=0, busy=0.
REQ-024 Reset in CAPT or HOLD SHALL abandon the in-flight word (not delivered); arbitration restarts from ptr=0.
REQ-025 No output SHALL depend on rst_n combinationally.

Verification
REQ-026 Single: out_ready=1, req=0x08, input 3=0xA5 -> next cycle sel=3, gnt=0x08 one cycle; following cycle out_data=0xA5, out_valid=1.
REQ-027 Rotation: MAX_BURST=1, req=0xFF held, out_ready=1 -> gnt order 0,1,2,...,7,0 (wrap), one word each.
REQ-028 Backpressure: req=0x01, out_ready=0 for 5 cycles after out_valid -> out_valid, out_data stable, gnt=0 throughout; out_ready=1 -> out_valid=0 next cycle.
REQ-029 Burst limit: MAX_BURST=4, req=0x20 held, out_ready=1 -> 4 gnt[5] pulses 2 cycles apart, one ARB cycle, then gnt[5] resumes.
REQ-030 Fairness: MAX_BURST=4, req=0x81 held, ptr=7 -> 4 words from 7, then 4 from 0, then 7 again.
REQ-031 Reset mid-HOLD with out_valid=1 -> next cycle out_valid=0, sel=0, busy=0; req=0x02 then granted as requester 1.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
//   Round-robin arbiter that steers an external 8:1 mux (sel) to one of eight
//   requesters, captures the selected word into a registered output, and
//   strobes gnt to pop that word from its requester. An owner may deliver up
//   to MAX_BURST consecutive words before the arbiter rotates past it.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   req[7:0]   : requester i has a word on mux input i
//   mux_out    : output of the external 8:1 mux selected by sel
//   sel[2:0]   : registered mux select
//   gnt[7:0]   : one-hot pop strobe, high only in the capture cycle
//   out_data   : captured word
//   out_valid  : out_data holds an undelivered word
//   out_ready  : downstream accepts out_data when out_valid is high
//   busy       : arbiter is not idle (not in ARB)
module rr_mux_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] mux_out,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

  typedef enum logic [1:0] {
    ARB,
    CAPT,
    HOLD
  } state_t;

  state_t     state;
  logic [2:0] owner;
  logic [2:0] ptr;
  logic [3:0] burst_cnt;

  logic [2:0] pick;
  logic       found;
  logic [2:0] idx;

  // First requester at or after ptr, wrapping modulo 8.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      idx = ptr + 3'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (state == CAPT) gnt[owner] = 1'b1;
  end

  assign busy = (state != ARB);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ARB;
      sel       <= '0;
      owner     <= '0;
      ptr       <= '0;
      burst_cnt <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        ARB: begin
          if (found) begin
            owner     <= pick;
            sel       <= pick;
            burst_cnt <= '0;
            state     <= CAPT;
          end
        end
        CAPT: begin
          // Word is taken even if req[owner] has already dropped.
          out_data  <= mux_out;
          out_valid <= 1'b1;
          burst_cnt <= burst_cnt + 4'd1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (req[owner] && (burst_cnt < BURST_LIMIT)) begin
              state <= CAPT;
            end else begin
              ptr   <= owner + 3'd1;
              state <= ARB;
            end
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter
//   Drives rr_mux_arbiter with directed scenarios followed by randomized
//   request/backpressure/reset traffic, and compares every cycle against a
//   behavioural model of the arbitration rules. The bench also plays the role
//   of the eight requesters and the external 8:1 mux.
module tb_rr_mux_arbiter;

  localparam int unsigned MB = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] mux_out;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  logic [7:0] src [8];

  int n_checks;
  int n_errors;

  // Behavioural model state
  int   m_ptr;
  int   m_owner;
  int   m_sel;
  int   m_words;
  logic [7:0] m_data;
  bit   m_valid;
  bit   m_taking;
  bit   m_engaged;

  rr_mux_arbiter #(.MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .mux_out   (mux_out),
    .sel       (sel),
    .gnt       (gnt),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb mux_out = src[sel];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_ptr = 0; m_owner = 0; m_sel = 0; m_words = 0;
    m_data = 8'h00; m_valid = 0; m_taking = 0; m_engaged = 0;
  endfunction

  // Advance the model across one rising edge given the inputs seen there.
  function automatic void model_edge(input logic [7:0] r, input logic rdy, input logic rn);
    if (!rn) begin
      model_reset();
    end else if (!m_engaged) begin
      if (r != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          int c;
          c = (m_ptr + k) % 8;
          if (r[c]) begin
            m_owner = c;
            break;
          end
        end
        m_sel = m_owner; m_words = 0; m_taking = 1; m_engaged = 1;
      end
    end else if (m_taking) begin
      m_data = src[m_owner]; m_valid = 1; m_words++; m_taking = 0;
    end else if (rdy) begin
      m_valid = 0;
      if (r[m_owner] && m_words < int'(MB)) begin
        m_taking = 1;
      end else begin
        m_ptr = (m_owner + 1) % 8;
        m_engaged = 0;
      end
    end
  endfunction

  // One clock cycle: compare outputs against the model, apply new inputs,
  // and let any requester that was granted present its next word.
  task automatic step(input logic [7:0] r, input logic rdy, input logic rn);
    logic [7:0] g_seen;
    logic [7:0] exp_gnt;
    @(negedge clk);
    exp_gnt = m_taking ? (8'h01 << m_owner) : 8'h00;
    check("sel", 32'(sel), 32'(m_sel));
    check("gnt", 32'(gnt), 32'(exp_gnt));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("busy", 32'(busy), 32'(m_engaged));
    if (m_valid) check("out_data", 32'(out_data), 32'(m_data));
    g_seen = gnt;
    req = r; out_ready = rdy; rst_n = rn;
    model_edge(r, rdy, rn);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++)
      if (g_seen[i]) src[i] = 8'($urandom);
  endtask

  initial begin
    logic [7:0] cur_req;
    logic       rdy;
    logic       rn;
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 8; i++) src[i] = 8'($urandom);
    req = '0; out_ready = 1'b1; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("reset_sel", 32'(sel), 32'd0);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_gnt", 32'(gnt), 32'd0);
    check("reset_data", 32'(out_data), 32'd0);

    // Single word from requester 3
    step(8'h00, 1'b1, 1'b1);
    src[3] = 8'hA5;
    step(8'h08, 1'b1, 1'b1);
    check("single_sel", 32'(sel), 32'd3);
    check("single_gnt", 32'(gnt), 32'h08);
    step(8'h00, 1'b1, 1'b1);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data", 32'(out_data), 32'hA5);
    check("single_gnt_off", 32'(gnt), 32'h00);
    repeat (3) step(8'h00, 1'b1, 1'b1);

    // Backpressure on requester 0
    step(8'h01, 1'b0, 1'b1);
    step(8'h01, 1'b0, 1'b1);
    repeat (5) begin
      step(8'h01, 1'b0, 1'b1);
      check("bp_gnt", 32'(gnt), 32'h00);
      check("bp_valid", 32'(out_valid), 32'd1);
    end
    step(8'h00, 1'b1, 1'b1);
    check("bp_release", 32'(out_valid), 32'd0);
    repeat (3) step(8'h00, 1'b1, 1'b1);

    // Burst limit on requester 5, then fairness 7/0 from ptr=7
    repeat (24) step(8'h20, 1'b1, 1'b1);
    repeat (4) step(8'h40, 1'b1, 1'b1);
    repeat (6) step(8'h00, 1'b1, 1'b1);
    repeat (40) step(8'h81, 1'b1, 1'b1);

    // Reset during HOLD, then requester 1
    step(8'h10, 1'b0, 1'b1);
    step(8'h10, 1'b0, 1'b1);
    step(8'h10, 1'b0, 1'b1);
    step(8'h10, 1'b0, 1'b0);
    check("rst_hold_valid", 32'(out_valid), 32'd0);
    check("rst_hold_sel", 32'(sel), 32'd0);
    check("rst_hold_busy", 32'(busy), 32'd0);
    step(8'h02, 1'b1, 1'b1);
    check("after_rst_sel", 32'(sel), 32'd1);
    check("after_rst_gnt", 32'(gnt), 32'h02);
    repeat (4) step(8'h00, 1'b1, 1'b1);

    // Randomized traffic
    cur_req = 8'hFF;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 3) == 0) cur_req = 8'h01 << $urandom_range(0, 7);
        else cur_req = 8'($urandom);
      end
      rdy = ($urandom_range(0, 3) != 0);
      rn  = ($urandom_range(0, 299) != 0);
      step(cur_req, rdy, rn);
    end
    step(8'h00, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
